mips_avalon_ram: RTL
====================

# mips_avalon_ram

Single-port, word-organised Avalon-MM slave RAM that sits directly downstream of `mips_cpu_bus` and services its instruction fetches and LW/SW data accesses. Inserts a programmable number of wait states per transfer via `waitrequest`, applies `byteenable` on writes, and returns read data the cycle after acceptance, matching the CPU's bus expectations. Two instances are used at system level: one at the reset vector `0xBFC00000` for program, one at a data base address.

## Interface
Parameters:
- `BASE_ADDR`, `32'hBFC00000`, byte address of word 0 of this instance's window.
- `ADDR_WIDTH`, `10`, log2 of depth in 32-bit words; window is `4 << ADDR_WIDTH` bytes.
- `WAIT_CYCLES`, `1`, wait states inserted per transfer (0..15).
- `INIT_FILE`, `""`, hex file loaded with `$readmemh` at time 0 when non-empty.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `address`  in  32  byte address from master; must be word aligned.
- `read`  in  1  read request, held until accepted.
- `write`  in  1  write request, held until accepted.
- `byteenable`  in  4  lane enables for writes; bit n = `writedata[8n+7:8n]`.
- `writedata`  in  32  write data.
- `waitrequest`  out  1  high = request not accepted this cycle.
- `readdata`  out  32  data of last accepted read.
- `bus_error`  out  1  sticky protocol/range error flag.

## Operation
- Request present = `read | write`. Wait counter `cnt` (4 bits) counts cycles the current request has been stalled.
- `waitrequest = reset | (request & (cnt < WAIT_CYCLES))`.
- Accept cycle: request present and `waitrequest` low. At that edge: transfer performed, `cnt <= 0`.
- Stall cycle: request present and `waitrequest` high: `cnt <= cnt + 1`.
- Idle (no request): `cnt <= 0`.
- In-window test: `address - BASE_ADDR < (4 << ADDR_WIDTH)` (32-bit unsigned subtraction, wraps). Word index = `(address - BASE_ADDR) >> 2`.
- Accepted write, in window, aligned: each lane with `byteenable[n]=1` updated; other lanes unchanged; `byteenable=4'b0000` is a legal no-op.
- Accepted read, in window, aligned: `readdata <= mem[index]`.
- Error cases, each sets `bus_error <= 1` (cleared only by reset):
  - `read & write` together: write performed, `readdata` unchanged.
  - `address[1:0] != 0` or out of window: write dropped; read returns `readdata <= 0`.
  - Request deasserted while `cnt != 0` (master abandoned stalled transfer): no transfer, `cnt <= 0`.
- `address`, `byteenable`, `writedata` are sampled only at the accept edge; changes during stall cycles are not errors.

## Timing
- Reset values: `cnt=0`, `readdata=32'h0`, `bus_error=0`; `waitrequest=1` throughout any cycle with `reset` high. Memory contents are not altered by reset; a transfer pending at reset is discarded.
- Latency: request asserted at cycle 0 is accepted in cycle `WAIT_CYCLES`; read data valid from cycle `WAIT_CYCLES+1` and held until the next accepted read.
- `WAIT_CYCLES=0`: `waitrequest` low whenever not in reset; back-to-back transfers accepted every cycle.
- Write then read of same word on consecutive accepts returns the new data (write-first ordering across cycles).
- `cnt` saturates at 15; with `WAIT_CYCLES` ≤ 15 saturation is never reached.

## Configuration
- `MIPS_AVALON_RAM_WAITSTATE_EN`: defined: counter and wait-state logic present, behaviour as above. Not defined: `cnt` removed, `waitrequest = reset`, every request accepted in the cycle presented regardless of `WAIT_CYCLES`; abandoned-transfer error cannot occur.

## Test plan
- `WAIT_CYCLES=2`, read `0xBFC00000` with `INIT_FILE` word0=`32'h24020005` -> `waitrequest` high cycles 0–1, low cycle 2, `readdata=32'h24020005` from cycle 3.
- Write `32'hAABBCCDD` to `0xBFC00010`, `byteenable=4'b1111`; then write `32'h11223344`, `byteenable=4'b0101`; read back -> `32'hAA22CC44`.
- Read `0xBFC00002` -> `bus_error=1`, `readdata=0`; read `0x00000000` (out of window) -> `readdata=0`, flag stays 1 until reset.
- `WAIT_CYCLES=3`, assert `read`, drop it after 1 stall cycle -> no transfer, `cnt` back to 0, `bus_error=1`.
- Assert `reset` mid-stall of a write of `32'hDEADBEEF` -> word unchanged, `waitrequest=1` during reset, `readdata=0`, `bus_error=0` after.
- Macro undefined, `WAIT_CYCLES=4`: back-to-back reads of words 0,1,2 -> `waitrequest` never high, data on cycles 1,2,3.

Source files
------------

// File: rtl/mips_avalon_ram.sv
// mips_avalon_ram: single-port, word-organised Avalon-MM slave RAM placed
// behind mips_cpu_bus.
//
// Wait states come from a per-request stall counter. Byte lanes are applied
// on writes. Read data is registered and becomes valid the cycle after the
// request is accepted.
//
// Optional feature: define MIPS_AVALON_RAM_WAITSTATE_EN to build in the stall
// counter. Without it every request is accepted in the cycle it is presented,
// and waitrequest only reflects reset.
module mips_avalon_ram #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int          DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [31:0] WINDOW = 32'd4 << ADDR_WIDTH;

    // The wait-state count must fit the 4-bit stall counter.
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("mips_avalon_ram: WAIT_CYCLES must be in 0..15");
    end

    logic [31:0]           mem [DEPTH];
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  addr_ok;
    logic                  request;
    logic                  accept;
    logic                  abandon;
    logic                  do_write;
    logic [3:0]            lane_we;
    logic [31:0]           readdata_q, readdata_d;
    logic                  bus_error_q, bus_error_d;

    // Wrapping subtraction: addresses below BASE_ADDR become huge and fail
    // the window test.
    assign offset   = address - BASE_ADDR;
    assign word_idx = offset[ADDR_WIDTH+1:2];
    assign addr_ok  = (offset < WINDOW) && (address[1:0] == 2'b00);
    assign request  = read | write;
    assign accept   = request & ~waitrequest;
    assign do_write = accept & write & addr_ok;

`ifdef MIPS_AVALON_RAM_WAITSTATE_EN
    localparam logic [3:0] WAIT_Q = 4'(WAIT_CYCLES);

    logic [3:0] cnt_q, cnt_d;

    assign waitrequest = reset | (request & (cnt_q < WAIT_Q));
    assign abandon     = ~request & (cnt_q != 4'd0);

    // Stall counter: advances while a request is held off, clears on accept or idle.
    always_comb begin
        cnt_d = 4'd0;
        if (request && waitrequest) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign waitrequest = reset;
    assign abandon     = 1'b0;
`endif

    // Per-lane write enables; lanes with byteenable low keep their old byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_we[gi] = do_write & byteenable[gi];
    end

    // Byte-lane memory write.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (lane_we[n]) begin
                mem[word_idx][8*n +: 8] <= writedata[8*n +: 8];
            end
        end
    end

    // Read-data and sticky error next state.
    always_comb begin
        readdata_d  = readdata_q;
        bus_error_d = bus_error_q;
        // A combined read+write performs only the write; readdata is left alone.
        if (accept && read && !write) begin
            readdata_d = addr_ok ? mem[word_idx] : 32'h0;
        end
        if ((accept && ((read && write) || !addr_ok)) || abandon) begin
            bus_error_d = 1'b1;
        end
    end

    // Read-data and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q  <= 32'h0;
            bus_error_q <= 1'b0;
        end else begin
            readdata_q  <= readdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign readdata  = readdata_q;
    assign bus_error = bus_error_q;

endmodule
